checkbits_latency_monitor: RTL and testbench
============================================

# checkbits_latency_monitor

Cycle-accurate latency monitor for the user project area. It watches the 16-bit checkpoint word that firmware drives onto mprj_io[31:16], detects start/end markers (0xAB<id>0 / 0xAB<id>1), and records per-test cycle counts. Results are readable over the Wishbone slave port, so FIR, matmul and qsort runtimes are measured in hardware rather than inferred from testbench waits.

## Interface
Parameters:
- NUM_TESTS, 4: number of test ids tracked; id = checkbits[7:4], valid range 0..NUM_TESTS-1.
- CNT_W, 32: cycle counter width (2..32).
- BASE_ADR, 32'h3000_0000: Wishbone base address; decode on wbs_adr_i[31:8].

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- checkbits  in  16  checkpoint word, same clock domain as wb_clk_i.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- done_irq  out  1  one-cycle pulse when a result is stored.

## Operation
- Registers cb_q <= checkbits each cycle; reset value 16'h0000. An event fires only in a cycle where checkbits != cb_q and checkbits[15:8] == 8'hAB, checkbits[3:0] is 0 (start) or 1 (end), and id < NUM_TESTS; anything else is ignored.
- FSM states IDLE, RUN. Reset -> IDLE, cnt = 0, cur_id = 0.
- IDLE + start(id): cnt <= 0, cur_id <= id, -> RUN.
- RUN: cnt increments each cycle and saturates at all-ones; on saturation set ovf (sticky).
- RUN + end(id == cur_id): result[id] <= cnt + 1 (saturating), valid[id] <= 1, done_irq pulses, -> IDLE.
- RUN + end(id != cur_id): set err (sticky), no store, -> IDLE.
- RUN + start(any id): set err, restart as for IDLE + start with the new id.
- IDLE + end: set err, stay IDLE.
- Re-running a test overwrites result[id] and keeps valid[id] = 1.
- Register map, offsets from BASE_ADR:
  - 0x00 STATUS (RO): [3:0] valid, [8] busy (RUN), [9] err, [10] ovf, [15:12] cur_id.
  - 0x04 CTRL (WO): bit0 = 1 clears valid, err, ovf and all results, and forces IDLE. Other bits are ignored.
  - 0x10 + 4*i RESULT[i] (RO), zero-extended to 32 bits.
  - Unmapped reads return 0. Writes to RO addresses are acked and ignored.
- A CTRL clear in the same cycle as a checkbits event: the clear wins, and the event is dropped.

## Timing
- Reset values: wbs_dat_o = 0, wbs_ack_o = 0, done_irq = 0; all results, valid, err and ovf = 0.
- Measured value = number of rising edges from the edge that samples the start word to the edge that samples the end word. Start sampled at edge N and end at edge N+K gives K.
- done_irq is asserted in the cycle after the end-sampling edge, for exactly one cycle.
- Wishbone: ack is registered and asserted one cycle after cyc&stb&address-hit, for one cycle only. Back-to-back strobes yield an ack every other cycle. wbs_dat_o is valid with ack and is 0 otherwise.
- A read of RESULT[i] in the same cycle it is updated returns the old value.
- wb_rst_i asserted mid-RUN clears everything immediately. After release, the FSM is in IDLE and an end marker alone sets err.

## Structure
- Shared package clm_pkg holds:
  - the marker constants (CB_TAG = 8'hAB, CB_START = 4'h0, CB_END = 4'h1);
  - the register offsets (STATUS, CTRL, RESULT_BASE);
  - the state enum {IDLE, RUN}.
- One sub-module, clm_wb_slave: address decode, ack generation and the read mux. Event decode, the FSM and the result storage stay in the top.

## Test plan
- Drive checkbits 0xAB00 then 0xAB01 100 cycles later -> RESULT[0] = 100, STATUS valid = 4'b0001, err = 0, one done_irq pulse.
- FIR, matmul and qsort sequences (0xAB00/01, 0xAB10/11, 0xAB20/21) with gaps of 50, 2000 and 7 cycles -> RESULT[0..2] = 50, 2000, 7; valid = 4'b0111.
- 0xAB10 then 0xAB01 -> err = 1, valid[1] = 0, busy = 0. Then write CTRL = 1 -> STATUS reads 0.
- CNT_W = 8, start, then 300 cycles, then end -> RESULT = 255, ovf = 1.
- Assert wb_rst_i 20 cycles after 0xAB00, release, then drive 0xAB01 -> busy = 0, err = 1, no done_irq.
- Drive 0xAB00, 0x1234, 0xAB00, 0xAB01: 0x1234 is ignored and 0xAB00 re-entry counts as a restart -> err = 1, and RESULT[0] is measured from the second start.

Source files
------------

// File: rtl/clm_pkg.sv
// Shared constants and types for the checkpoint latency monitor.
package clm_pkg;

    localparam logic [7:0] CB_TAG   = 8'hAB;
    localparam logic [3:0] CB_START = 4'h0;
    localparam logic [3:0] CB_END   = 4'h1;

    localparam logic [7:0] OFF_STATUS      = 8'h00;
    localparam logic [7:0] OFF_CTRL        = 8'h04;
    localparam logic [7:0] OFF_RESULT_BASE = 8'h10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/clm_wb_slave.sv
// Wishbone slave for the latency monitor: address decode, registered ack,
// read mux and the CTRL clear strobe.
module clm_wb_slave
    import clm_pkg::*;
#(
    parameter int          NUM_TESTS = 4,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] BASE_ADR  = 32'h3000_0000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wbs_cyc_i,
    input  logic                            wbs_stb_i,
    input  logic                            wbs_we_i,
    input  logic [31:0]                     wbs_adr_i,
    input  logic [31:0]                     wbs_dat_i,
    input  logic [31:0]                     status_i,
    input  logic [NUM_TESTS-1:0][CNT_W-1:0] results_i,
    output logic [31:0]                     wbs_dat_o,
    output logic                            wbs_ack_o,
    output logic                            ctrl_clr_o
);

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rdata;
    logic [7:0]  offset;
    logic        hit, accept;
    logic        unused_dat;

    assign offset     = wbs_adr_i[7:0];
    assign hit        = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    // Suppressing accept while ack is high gives one ack per strobe pair.
    assign accept     = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
    assign ctrl_clr_o = accept & wbs_we_i & (offset == OFF_CTRL) & wbs_dat_i[0];
    assign unused_dat = ^wbs_dat_i[31:1];

    always_comb begin
        rdata = '0;
        if (offset == OFF_STATUS) rdata = status_i;
        for (int i = 0; i < NUM_TESTS; i++) begin
            if (offset == OFF_RESULT_BASE + 8'(4 * i)) rdata = 32'(results_i[i]);
        end
    end

    always_comb begin
        ack_d = accept;
        dat_d = (accept && !wbs_we_i) ? rdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

endmodule

// File: rtl/checkbits_latency_monitor.sv
// Watches the firmware checkpoint word for start/end markers and records
// per-test cycle counts, readable over Wishbone.
module checkbits_latency_monitor
    import clm_pkg::*;
#(
    parameter int          NUM_TESTS = 4,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] BASE_ADR  = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] checkbits,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        done_irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                         state_q, state_d;
    logic [15:0]                    cb_q;
    logic [CNT_W-1:0]               cnt_q, cnt_d, cnt_inc;
    logic [3:0]                     cur_id_q, cur_id_d;
    logic [NUM_TESTS-1:0][CNT_W-1:0] result_q, result_d;
    logic [NUM_TESTS-1:0]           valid_q, valid_d;
    logic                           err_q, err_d;
    logic                           ovf_q, ovf_d;
    logic                           done_q, done_d;

    logic [3:0]  ev_id;
    logic        ev_ok, ev_start, ev_end;
    logic        clr;
    logic [31:0] status;

    // A marker only counts on the cycle the word changes.
    assign ev_id    = checkbits[7:4];
    assign ev_ok    = (checkbits != cb_q) && (checkbits[15:8] == CB_TAG) &&
                      ({28'd0, ev_id} < 32'(NUM_TESTS));
    assign ev_start = ev_ok && (checkbits[3:0] == CB_START);
    assign ev_end   = ev_ok && (checkbits[3:0] == CB_END);
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            cb_q     <= '0;
            cnt_q    <= '0;
            cur_id_q <= '0;
            result_q <= '0;
            valid_q  <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cb_q     <= checkbits;
            cnt_q    <= cnt_d;
            cur_id_q <= cur_id_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr)           state_d = IDLE;
        else if (ev_start) state_d = RUN;
        else if (ev_end)   state_d = IDLE;
    end

    always_comb begin
        cnt_d    = cnt_q;
        cur_id_d = cur_id_q;
        result_d = result_q;
        valid_d  = valid_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        if (clr) begin
            cnt_d    = '0;
            cur_id_d = '0;
            result_d = '0;
            valid_d  = '0;
            err_d    = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            if (state_q == RUN) begin
                cnt_d = cnt_inc;
                if (cnt_q == CNT_MAX) ovf_d = 1'b1;
            end
            if (ev_start) begin
                if (state_q == RUN) err_d = 1'b1;
                cnt_d    = '0;
                cur_id_d = ev_id;
            end else if (ev_end) begin
                if (state_q == IDLE || ev_id != cur_id_q) begin
                    err_d = 1'b1;
                end else begin
                    // cnt lags the edge count by one; the end edge itself completes it.
                    for (int i = 0; i < NUM_TESTS; i++) begin
                        if (4'(i) == ev_id) begin
                            result_d[i] = cnt_inc;
                            valid_d[i]  = 1'b1;
                        end
                    end
                    done_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        status = '0;
        for (int i = 0; i < NUM_TESTS && i < 4; i++) status[i] = valid_q[i];
        status[8]     = (state_q == RUN);
        status[9]     = err_q;
        status[10]    = ovf_q;
        status[15:12] = cur_id_q;
    end

    assign done_irq = done_q;

    clm_wb_slave #(
        .NUM_TESTS (NUM_TESTS),
        .CNT_W     (CNT_W),
        .BASE_ADR  (BASE_ADR)
    ) u_wb (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .status_i   (status),
        .results_i  (result_q),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_ack_o  (wbs_ack_o),
        .ctrl_clr_o (clr)
    );

endmodule

// File: tb/tb_checkbits_latency_monitor.sv
// Bench for checkbits_latency_monitor: a 32-bit and an 8-bit counter instance
// share one stimulus stream and are compared each cycle to an edge-count model.
module tb_checkbits_latency_monitor;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cb = 16'h0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic [31:0] dat0, dat1;
    logic        ack0, ack1, irq0, irq1;

    always #5 clk = ~clk;

    checkbits_latency_monitor #(.NUM_TESTS(4), .CNT_W(32), .BASE_ADR(BASE)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .checkbits(cb),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_dat_o(dat0), .wbs_ack_o(ack0), .done_irq(irq0));

    checkbits_latency_monitor #(.NUM_TESTS(4), .CNT_W(8), .BASE_ADR(BASE)) u_small (
        .wb_clk_i(clk), .wb_rst_i(rst), .checkbits(cb),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_dat_o(dat1), .wbs_ack_o(ack1), .done_irq(irq1));

    int n_pass = 0, n_total = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Model: a test's result is the number of edges since its start edge, capped.
    int unsigned cw [2] = '{32, 8};
    bit          m_run [2];
    longint      m_start [2];
    int          m_cur [2];
    longint      m_res [2][4];
    bit [3:0]    m_valid [2];
    bit          m_err [2], m_ovf [2], m_done [2];
    logic [31:0] m_dat [2];
    bit          m_ack;
    logic [15:0] m_cb;
    longint      edge_n;

    function automatic logic [31:0] model_read(input int k, input logic [7:0] off);
        int idx;
        if (off == 8'h00)
            return {16'h0, 4'(m_cur[k]), 1'b0, m_ovf[k], m_err[k], m_run[k], 4'h0, m_valid[k]};
        if (off >= 8'h10 && off < 8'h20 && off[1:0] == 2'b00) begin
            idx = (int'(off) - 16) / 4;
            return 32'(m_res[k][idx]);
        end
        return 32'h0;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit req, acc, clr, evs, eve;
        int id;
        longint el, mx;
        if (rst) begin
            edge_n = 0; m_ack = 0; m_cb = 16'h0;
            for (int k = 0; k < 2; k++) begin
                m_run[k] = 0; m_start[k] = 0; m_cur[k] = 0; m_valid[k] = 0;
                m_err[k] = 0; m_ovf[k] = 0; m_done[k] = 0; m_dat[k] = 32'h0;
                for (int t = 0; t < 4; t++) m_res[k][t] = 0;
            end
        end else begin
            edge_n++;
            req = cyc && stb && (adr[31:8] == BASE[31:8]);
            acc = req && !m_ack;
            clr = acc && we && (adr[7:0] == 8'h04) && wdat[0];
            id  = int'(cb[7:4]);
            evs = (cb != m_cb) && (cb[15:8] == 8'hAB) && (id < 4) && (cb[3:0] == 4'h0);
            eve = (cb != m_cb) && (cb[15:8] == 8'hAB) && (id < 4) && (cb[3:0] == 4'h1);
            for (int k = 0; k < 2; k++) begin
                m_dat[k]  = (acc && !we) ? model_read(k, adr[7:0]) : 32'h0;
                m_done[k] = 0;
                if (clr) begin
                    m_run[k] = 0; m_cur[k] = 0; m_valid[k] = 0; m_err[k] = 0; m_ovf[k] = 0;
                    for (int t = 0; t < 4; t++) m_res[k][t] = 0;
                end else begin
                    mx = (64'd1 << cw[k]) - 1;
                    el = edge_n - m_start[k];
                    if (m_run[k] && el > mx) m_ovf[k] = 1;
                    if (evs) begin
                        if (m_run[k]) m_err[k] = 1;
                        m_run[k] = 1; m_start[k] = edge_n; m_cur[k] = id;
                    end else if (eve) begin
                        if (!m_run[k] || id != m_cur[k]) m_err[k] = 1;
                        else begin
                            m_res[k][id] = (el > mx) ? mx : el;
                            m_valid[k][id] = 1;
                            m_done[k] = 1;
                        end
                        m_run[k] = 0;
                    end
                end
            end
            m_ack = acc;
            m_cb  = cb;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("ack", ack0, m_ack);
            chk("ack_small", ack1, m_ack);
            chk("dat", dat0, m_dat[0]);
            chk("dat_small", dat1, m_dat[1]);
            chk("irq", irq0, m_done[0]);
            chk("irq_small", irq1, m_done[1]);
            if (irq0) done_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] d0, output logic [31:0] d1);
        bit got;
        got = 0; d0 = 32'h0; d1 = 32'h0;
        cyc = 1; stb = 1; we = w; adr = a; wdat = d;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ack0) begin got = 1; d0 = dat0; d1 = dat1; end
        end
        if (!got) chk("ack_timeout", 0, 1);
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] d0, output logic [31:0] d1);
        wb_xfer(1'b0, BASE | 32'(off), 32'h0, d0, d1);
    endtask

    task automatic clear();
        logic [31:0] x0, x1;
        wb_xfer(1'b1, BASE | 32'h4, 32'h1, x0, x1);
    endtask

    initial begin
        logic [31:0] d0, d1;
        logic [31:0] a;
        int r;
        logic [7:0] tag;

        tick(3);
        rst = 0;
        @(negedge clk);
        chk("reset_ack", ack0, 0);
        chk("reset_dat", dat0, 0);
        chk("reset_irq", irq0, 0);
        tick(1);
        rd(8'h00, d0, d1);
        chk("reset_status", d0, 32'h0);

        // Single test, 100 cycles
        done_cnt = 0;
        cb = 16'hAB00; tick(100);
        cb = 16'hAB01; tick(3);
        rd(8'h10, d0, d1);
        chk("t1_result0", d0, 100);
        chk("t1_result0_small", d1, 100);
        rd(8'h00, d0, d1);
        chk("t1_status", d0, 32'h0001);
        chk("t1_irq_count", done_cnt, 1);

        // FIR / matmul / qsort
        cb = 16'hAB00; tick(50);   cb = 16'hAB01; tick(3);
        cb = 16'hAB10; tick(2000); cb = 16'hAB11; tick(3);
        cb = 16'hAB20; tick(7);    cb = 16'hAB21; tick(3);
        rd(8'h10, d0, d1); chk("t2_fir", d0, 50);
        rd(8'h14, d0, d1); chk("t2_matmul", d0, 2000); chk("t2_matmul_small", d1, 255);
        rd(8'h18, d0, d1); chk("t2_qsort", d0, 7);
        rd(8'h00, d0, d1); chk("t2_status", d0, 32'h2007); chk("t2_status_small", d1, 32'h2407);

        // Mismatched end id
        clear();
        cb = 16'hAB10; tick(5);
        cb = 16'hAB01; tick(2);
        rd(8'h00, d0, d1); chk("t3_status_err", d0, 32'h1200);
        clear();
        rd(8'h00, d0, d1); chk("t3_status_clr", d0, 32'h0); chk("t3_status_clr_small", d1, 32'h0);

        // Saturation on the 8-bit instance
        cb = 16'hAB30; tick(300);
        cb = 16'hAB31; tick(2);
        rd(8'h1C, d0, d1); chk("t4_result3", d0, 300); chk("t4_result3_small", d1, 255);
        rd(8'h00, d0, d1); chk("t4_status", d0, 32'h3008); chk("t4_status_small", d1, 32'h3408);

        // Reset mid-run, then a lone end marker
        cb = 16'hAB00; tick(20);
        rst = 1; cb = 16'h0000; tick(2);
        rst = 0; tick(2);
        done_cnt = 0;
        cb = 16'hAB01; tick(3);
        rd(8'h00, d0, d1); chk("t5_status", d0, 32'h0200);
        chk("t5_irq_count", done_cnt, 0);

        // Noise word ignored, re-entered start restarts the measurement
        clear();
        cb = 16'hAB00; tick(10);
        cb = 16'h1234; tick(5);
        cb = 16'hAB00; tick(30);
        cb = 16'hAB01; tick(2);
        rd(8'h10, d0, d1); chk("t6_result0", d0, 30);
        rd(8'h00, d0, d1); chk("t6_status", d0, 32'h0201);

        // Clear and start sampled on the same edge: clear wins
        cb = 16'hAB20;
        clear();
        tick(2);
        rd(8'h00, d0, d1); chk("t7_clear_wins", d0, 32'h0);

        // Randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 11);
            if (r < 7) begin
                tag = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hAB;
                cb = {tag, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 2))};
                tick($urandom_range(1, 40));
            end else if (r < 10) begin
                rd(8'($urandom_range(0, 15) << 2), d0, d1);
            end else if (r == 10) begin
                a = ($urandom_range(0, 1) == 0) ? (BASE | 32'h4) : (BASE | 32'h10);
                wb_xfer(1'b1, a, 32'($urandom_range(0, 3)), d0, d1);
            end else begin
                cyc = 1; stb = 1; we = 0; adr = 32'h2000_0000;
                tick(3);
                cyc = 0; stb = 0;
            end
        end
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
